// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, widths and
// the two's-complement negation used for sign handling.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [DIV_W-1:0] negate(input logic [DIV_W-1:0] x);
    return ~x + DIV_W'(1);
  endfunction

endpackage

// File: rtl/add32.sv
// 32-bit ripple-free behavioural adder with carry in/out, shared with the ALU
// datapath and reused here for the divider's trial subtraction.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] out,
  output logic        c_out
);

  assign {c_out, out} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed operands
// handled as magnitudes with a sign fixup on the way out.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_qAcc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_qNeg;
  logic               r_rNeg;
  logic               r_zero;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;

  logic               w_accept;
  logic               w_divZero;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_shift;
  logic [WIDTH-1:0]   w_trial;
  logic               w_cout;
  logic               w_take;

  assign w_accept  = start && (r_state == ST_IDLE);
  assign w_divZero = (divisor == '0);
  assign w_aNeg    = is_signed && dividend[WIDTH-1];
  assign w_bNeg    = is_signed && divisor[WIDTH-1];

  assign w_shift = {r_rem[WIDTH-2:0], r_a[WIDTH-1]};

  add32 u_add32 (
    .a     (w_shift),
    .b     (~r_b),
    .c_in  (1'b1),
    .out   (w_trial),
    .c_out (w_cout)
  );

  // The bit shifted out of r_rem is the 33rd bit of the partial remainder;
  // when set, the shifted value certainly exceeds the divisor.
  assign w_take = w_cout | r_rem[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = w_divZero ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(WIDTH-1)) begin
          w_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_qAcc      <= '0;
      r_cnt       <= '0;
      r_qNeg      <= 1'b0;
      r_rNeg      <= 1'b0;
      r_zero      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // A zero divisor keeps the raw dividend so it can be returned untouched.
            r_a    <= (w_aNeg && !w_divZero) ? negate(dividend) : dividend;
            r_b    <= w_bNeg ? negate(divisor) : divisor;
            r_qNeg <= w_aNeg ^ w_bNeg;
            r_rNeg <= w_aNeg;
            r_zero <= w_divZero;
            r_rem  <= '0;
            r_qAcc <= '0;
            r_cnt  <= '0;
            r_dbz  <= 1'b0;
          end
        end
        ST_CALC: begin
          r_rem  <= w_take ? w_trial : w_shift;
          r_a    <= {r_a[WIDTH-2:0], 1'b0};
          r_qAcc <= {r_qAcc[WIDTH-2:0], w_take};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        ST_FIN: begin
          r_done <= 1'b1;
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_a;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= r_qNeg ? negate(r_qAcc) : r_qAcc;
            r_remainder <= r_rNeg ? negate(r_rem) : r_rem;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
